// File: rtl/wb_retire_stage.sv
// Write-back / retire stage: formats the result, drives the register-file
// write port and the forwarding bus, and keeps the minstret counter.
module wb_retire_stage #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_trap,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_rd_we,
  input  logic [1:0]        i_sel,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_load_data,
  input  logic [2:0]        i_load_funct3,
  input  logic [1:0]        i_addr_lsb,
  input  logic [31:0]       i_csr_rdata,
  input  logic [31:0]       i_pc_plus4,
  input  logic              i_cnt_wr_lo,
  input  logic              i_cnt_wr_hi,
  input  logic [31:0]       i_cnt_wdata,
  output logic              o_rf_we,
  output logic [REG_AW-1:0] o_rf_waddr,
  output logic [31:0]       o_rf_wdata,
  output logic              o_fwd_valid,
  output logic [REG_AW-1:0] o_fwd_rd,
  output logic [31:0]       o_fwd_data,
  output logic [CNT_W-1:0]  o_instret
);

  localparam int HI_W = CNT_W - 32;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_CSR  = 2'd2,
    SEL_PC4  = 2'd3
  } sel_e;

  logic              accept, retire;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_fmt;
  logic [31:0]       result;

  logic              rf_we_d, rf_we_q;
  logic [REG_AW-1:0] waddr_d, waddr_q;
  logic [31:0]       wdata_d, wdata_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Acceptance depends only on hold, so ready never waits on valid.
  assign o_ready = ~i_hold;
  assign accept  = i_valid & ~i_hold & ~i_flush;
  assign retire  = accept & ~i_trap;

  // Load extraction: pick byte/halfword lane, then extend per funct3.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = i_addr_lsb[1] ? i_load_data[31:16] : i_load_data[15:0];
    ld_fmt  = 32'h0;
    case (i_addr_lsb)
      2'd0: ld_byte = i_load_data[7:0];
      2'd1: ld_byte = i_load_data[15:8];
      2'd2: ld_byte = i_load_data[23:16];
      2'd3: ld_byte = i_load_data[31:24];
      default: ld_byte = 8'h00;
    endcase
    case (i_load_funct3)
      3'b000: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001: ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b010: ld_fmt = i_load_data;
      3'b100: ld_fmt = {24'h0, ld_byte};
      3'b101: ld_fmt = {16'h0, ld_half};
      default: ld_fmt = 32'h0;
    endcase
  end

  // Result source mux.
  always_comb begin
    result = i_alu_result;
    case (sel_e'(i_sel))
      SEL_ALU:  result = i_alu_result;
      SEL_LOAD: result = ld_fmt;
      SEL_CSR:  result = i_csr_rdata;
      SEL_PC4:  result = i_pc_plus4;
      default:  result = i_alu_result;
    endcase
  end

  // Write-port next state: addr/data only move on retire, x0 never writes.
  always_comb begin
    rf_we_d = retire & i_rd_we & (i_rd != '0);
    waddr_d = retire ? i_rd   : waddr_q;
    wdata_d = retire ? result : wdata_q;
  end

  // Counter next state: any CSR write suppresses that cycle's increment.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_wr_lo || i_cnt_wr_hi) begin
      if (i_cnt_wr_lo) cnt_d[31:0] = i_cnt_wdata;
      if (i_cnt_wr_hi) cnt_d[CNT_W-1:32] = i_cnt_wdata[HI_W-1:0];
    end else if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any captured instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rf_we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_rf_we    = rf_we_q;
  assign o_rf_waddr = waddr_q;
  assign o_rf_wdata = wdata_q;
  assign o_instret  = cnt_q;

  generate
    if (FWD_EN) begin : g_fwd
      assign o_fwd_valid = rf_we_q;
      assign o_fwd_rd    = waddr_q;
      assign o_fwd_data  = wdata_q;
    end else begin : g_nofwd
      assign o_fwd_valid = 1'b0;
      assign o_fwd_rd    = '0;
      assign o_fwd_data  = '0;
    end
  endgenerate

  // Upper write-data bits have no home when the counter is narrower than 64.
  logic unused_wdata;
  assign unused_wdata = ^i_cnt_wdata;

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: default build plus a FWD_EN=0 build
// sharing the same stimulus.
module tb_wb_retire_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, hold, flush, trap, rd_we;
  logic [4:0]  rd;
  logic [1:0]  sel, addr_lsb;
  logic [31:0] alu, ldata, csr, pc4, cwdata;
  logic [2:0]  f3;
  logic        wr_lo, wr_hi;

  logic        ready, rf_we, fwd_valid;
  logic [4:0]  waddr, fwd_rd;
  logic [31:0] wdata, fwd_data;
  logic [63:0] instret;

  logic        ready0, rf_we0, fwd_valid0;
  logic [4:0]  waddr0, fwd_rd0;
  logic [31:0] wdata0, fwd_data0;
  logic [63:0] instret0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_retire_stage #(.REG_AW(5), .CNT_W(64), .FWD_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_hold(hold), .i_flush(flush), .i_trap(trap), .i_rd(rd), .i_rd_we(rd_we),
    .i_sel(sel), .i_alu_result(alu), .i_load_data(ldata), .i_load_funct3(f3),
    .i_addr_lsb(addr_lsb), .i_csr_rdata(csr), .i_pc_plus4(pc4),
    .i_cnt_wr_lo(wr_lo), .i_cnt_wr_hi(wr_hi), .i_cnt_wdata(cwdata),
    .o_rf_we(rf_we), .o_rf_waddr(waddr), .o_rf_wdata(wdata),
    .o_fwd_valid(fwd_valid), .o_fwd_rd(fwd_rd), .o_fwd_data(fwd_data),
    .o_instret(instret)
  );

  wb_retire_stage #(.REG_AW(5), .CNT_W(64), .FWD_EN(1'b0)) dut_nofwd (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready0),
    .i_hold(hold), .i_flush(flush), .i_trap(trap), .i_rd(rd), .i_rd_we(rd_we),
    .i_sel(sel), .i_alu_result(alu), .i_load_data(ldata), .i_load_funct3(f3),
    .i_addr_lsb(addr_lsb), .i_csr_rdata(csr), .i_pc_plus4(pc4),
    .i_cnt_wr_lo(wr_lo), .i_cnt_wr_hi(wr_hi), .i_cnt_wdata(cwdata),
    .o_rf_we(rf_we0), .o_rf_waddr(waddr0), .o_rf_wdata(wdata0),
    .o_fwd_valid(fwd_valid0), .o_fwd_rd(fwd_rd0), .o_fwd_data(fwd_data0),
    .o_instret(instret0)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; hold = 0; flush = 0; trap = 0; rd_we = 0; rd = '0; sel = '0;
    wr_lo = 0; wr_hi = 0;
  endtask

  task automatic issue(input logic [4:0] r, input logic [1:0] s);
    valid = 1; rd_we = 1; rd = r; sel = s;
  endtask

  initial begin
    rst_n = 0; idle();
    alu = 0; ldata = 0; csr = 0; pc4 = 0; f3 = 0; addr_lsb = 0; cwdata = 0;
    #12;
    check("rst_rf_we",   64'(rf_we), 64'd0);
    check("rst_fwd",     64'(fwd_valid), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_ready",   64'(ready), 64'd1);
    @(negedge clk); rst_n = 1;
    step();

    // Back-to-back ALU results, one per cycle.
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 2'd0); alu = 32'(i * 'h11);
      step();
      check("b2b_we",    64'(rf_we), 64'd1);
      check("b2b_addr",  64'(waddr), 64'(i));
      check("b2b_data",  64'(wdata), 64'(i * 'h11));
      check("b2b_fwdrd", 64'(fwd_rd), 64'(i));
    end
    idle(); step();
    check("b2b_idle_we",  64'(rf_we), 64'd0);
    check("b2b_instret",  instret, 64'd4);
    check("b2b_hold_dat", 64'(wdata), 64'h44);

    // Load formatting on 0x80F07F81.
    ldata = 32'h80F0_7F81;
    issue(5'd5, 2'd1); f3 = 3'b000; addr_lsb = 2'd0; step();
    check("lb_0",  64'(wdata), 64'hFFFF_FF81);
    f3 = 3'b100; addr_lsb = 2'd3; step();
    check("lbu_3", 64'(wdata), 64'h0000_0080);
    f3 = 3'b001; addr_lsb = 2'd2; step();
    check("lh_2",  64'(wdata), 64'hFFFF_80F0);
    f3 = 3'b101; addr_lsb = 2'd0; step();
    check("lhu_0", 64'(wdata), 64'h0000_7F81);
    f3 = 3'b011; step();
    check("f3_011", 64'(wdata), 64'h0);
    f3 = 3'b010; step();
    check("lw",    64'(wdata), 64'h80F0_7F81);
    check("ld_instret", instret, 64'd10);

    // x0 write suppressed but still retires.
    issue(5'd0, 2'd0); alu = 32'h1234; step();
    check("x0_we",      64'(rf_we), 64'd0);
    check("x0_instret", instret, 64'd11);

    // Trap: no write, no count, data held.
    issue(5'd3, 2'd0); alu = 32'hAAAA; trap = 1; step();
    check("trap_we",      64'(rf_we), 64'd0);
    check("trap_instret", instret, 64'd11);
    check("trap_addr",    64'(waddr), 64'd0);
    trap = 0;

    // Flush wins over valid.
    flush = 1; step();
    check("flush_we",      64'(rf_we), 64'd0);
    check("flush_instret", instret, 64'd11);
    flush = 0;

    // Hold: ready drops combinationally, nothing accepted.
    hold = 1; #1;
    check("hold_ready", 64'(ready), 64'd0);
    step();
    check("hold_we",      64'(rf_we), 64'd0);
    check("hold_instret", instret, 64'd11);
    hold = 0;

    // CSR and PC+4 selects; forwarding off in the second build.
    issue(5'd7, 2'd2); csr = 32'hDEAD_BEEF; step();
    check("csr_data",  64'(wdata), 64'hDEAD_BEEF);
    check("csr_addr",  64'(waddr), 64'd7);
    check("csr_fwd",   64'(fwd_data), 64'hDEAD_BEEF);
    check("csr_fwdv",  64'(fwd_valid), 64'd1);
    check("nofwd_v",   64'(fwd_valid0), 64'd0);
    check("nofwd_d",   64'(fwd_data0), 64'd0);
    check("nofwd_rfwe", 64'(rf_we0), 64'd1);
    issue(5'd8, 2'd3); pc4 = 32'h104; step();
    check("pc4_data",  64'(wdata), 64'h104);
    check("pc4_instret", instret, 64'd13);

    // Counter: write all-ones, then one retire wraps to 0.
    idle(); wr_lo = 1; wr_hi = 1; cwdata = 32'hFFFF_FFFF; step();
    check("cnt_ones", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    wr_lo = 0; wr_hi = 0; issue(5'd1, 2'd0); step();
    check("cnt_wrap", instret, 64'd0);

    // CSR write beats a same-cycle retire.
    issue(5'd2, 2'd0); wr_lo = 1; cwdata = 32'd5; step();
    check("cnt_wr_win", instret, 64'd5);
    check("cnt_wr_rfwe", 64'(rf_we), 64'd1);
    idle(); wr_hi = 1; cwdata = 32'd1; step();
    check("cnt_wr_hi", instret, 64'h1_0000_0005);
    wr_hi = 0;

    // Write lo only with a retire: upper bits keep their old value.
    issue(5'd2, 2'd0); wr_lo = 1; cwdata = 32'hFFFF_FFFF; step();
    check("cnt_lo_keep_hi", instret, 64'h1_FFFF_FFFF);
    wr_lo = 0; step();
    check("cnt_carry", instret, 64'h2_0000_0000);

    // Asynchronous reset mid-stream.
    issue(5'd9, 2'd0); alu = 32'h99; step();
    check("pre_rst_we", 64'(rf_we), 64'd1);
    #2 rst_n = 0; #1;
    check("arst_we",      64'(rf_we), 64'd0);
    check("arst_fwd",     64'(fwd_valid), 64'd0);
    check("arst_instret", instret, 64'd0);
    idle();
    @(negedge clk); rst_n = 1;
    step(); step();
    check("post_rst_we",   64'(rf_we), 64'd0);
    check("post_rst_addr", 64'(waddr), 64'd0);
    check("post_rst_cnt",  instret, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_retire_stage.md
# wb_retire_stage

Parametrised write-back and retire stage for the RV32I_Zicsr pipeline. It sits after the memory stage and provides three functions:
- accepts one instruction per cycle over a valid/ready handshake;
- selects and formats the result (ALU, load with byte/halfword extraction and sign extension, CSR read data, PC+4), then drives the register-file write port and the forwarding bus;
- maintains the retired-instruction counter backing minstret/minstreth, including CSR software writes.

## Interface
Parameters
- REG_AW, 5: register address width (4 for RV32E).
- CNT_W, 64: instret counter width, legal range 33..64.
- FWD_EN, 1: 1 drives the forwarding bus; 0 ties o_fwd_* to zero.

Ports
- i_clk  in  1  CPU clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active low.
- i_valid  in  1  memory stage presents an instruction.
- o_ready  out  1  stage can accept; equals ~i_hold.
- i_hold  in  1  debug/halt hold; blocks acceptance.
- i_flush  in  1  discard the instruction presented this cycle.
- i_trap  in  1  presented instruction trapped: no register write, no retire count.
- i_rd  in  REG_AW  destination register.
- i_rd_we  in  1  instruction writes rd.
- i_sel  in  2  result source: 0 ALU, 1 load, 2 CSR, 3 PC+4.
- i_alu_result  in  32  ALU result.
- i_load_data  in  32  raw aligned load word.
- i_load_funct3  in  3  load type.
- i_addr_lsb  in  2  load byte offset.
- i_csr_rdata  in  32  CSR read data.
- i_pc_plus4  in  32  link value.
- i_cnt_wr_lo  in  1  CSR write of counter bits [31:0].
- i_cnt_wr_hi  in  1  CSR write of counter bits [CNT_W-1:32].
- i_cnt_wdata  in  32  CSR write data.
- o_rf_we  out  1  register-file write enable.
- o_rf_waddr  out  REG_AW  write address.
- o_rf_wdata  out  32  write data.
- o_fwd_valid  out  1  forwarding bus valid.
- o_fwd_rd  out  REG_AW  forwarding destination.
- o_fwd_data  out  32  forwarding data.
- o_instret  out  CNT_W  retired-instruction count.

## Operation
- Accept: the stage accepts when `i_valid && o_ready && !i_flush`. The retire condition is accept and `!i_trap`.
- Load formatting: the byte is selected by i_addr_lsb and the halfword by i_addr_lsb[1].
  - 000 LB: sign-extend.
  - 001 LH: sign-extend.
  - 010 LW: whole word.
  - 100 LBU: zero-extend.
  - 101 LHU: zero-extend.
  - 011/110/111: result is 0.
- Register write: pipeline registers capture i_rd and the selected/formatted data on retire. o_rf_we is set on retire only when `i_rd_we && i_rd != 0`; x0 writes are always suppressed.
- Forwarding bus: mirrors the rf outputs (same register, same cycle) when FWD_EN=1.
- Cycles without retire (bubble, hold, flush, trap): o_rf_we and o_fwd_valid clear to 0. waddr/wdata hold their previous values.
- Counter:
  - Increments by 1 on each retire and wraps from all-ones to 0.
  - i_cnt_wr_lo replaces bits [31:0]; i_cnt_wr_hi replaces the upper CNT_W-32 bits (lower bits of i_cnt_wdata).
  - Simultaneous lo and hi writes apply both.
  - A CSR write in the same cycle as a retire wins; that retire's increment is dropped.
  - The CSR write is independent of i_hold and i_flush.
- Reset: all outputs and the counter are 0 during reset, except o_ready, which follows ~i_hold. Reset mid-operation discards the captured instruction; no write appears after release.

## Timing
- Latency is 1: an instruction retired at edge N drives o_rf_we/o_rf_waddr/o_rf_wdata/o_fwd_* during cycle N to N+1.
- o_instret shows the incremented value after edge N.
- Throughput is one instruction per cycle with no internal bubbles.
- o_ready is combinational from i_hold only; it does not depend on i_valid.
- Handshake: the upstream stage holds its payload while `i_valid && !o_ready`. While i_hold=1 nothing is accepted and outputs go idle the next cycle.
- i_flush takes priority over i_valid in the same cycle.
- CSR writes take effect at the edge; the new value is visible the following cycle.

## Test plan
- Reset: i_rst_n=0 mid-stream with o_rf_we=1 → o_rf_we, o_fwd_valid and o_instret are 0 immediately (asynchronous); after release with no i_valid they remain 0.
- Back-to-back: 4 cycles of ALU results (rd=1..4, data 0x11..0x44) → o_rf_we=1 on 4 consecutive cycles with matching addr/data one cycle late; o_instret=4.
- Load formatting: i_load_data=0x80F0_7F81 with these inputs:
  - LB, lsb=0 → 0xFFFFFF81
  - LBU, lsb=3 → 0x00000080
  - LH, lsb=2 → 0xFFFF80F0
  - LHU, lsb=0 → 0x00007F81
  - funct3=011 → 0
- Suppression: rd=0 with i_rd_we=1 → o_rf_we=0 and instret +1. i_trap=1 → no write, no increment. i_flush=1 → no write, no increment. i_hold=1 → o_ready=0 and nothing accepted.
- Counter:
  - Write lo=0xFFFFFFFF and hi=0xFFFFFFFF, then one retire → o_instret=0 (wrap).
  - i_cnt_wr_lo with data 5 in the same cycle as a retire → o_instret=5.
- CSR/PC+4 select: i_sel=2 with csr_rdata=0xDEAD_BEEF, rd=7 → wdata 0xDEADBEEF. i_sel=3 with pc_plus4=0x104 → wdata 0x104. FWD_EN=0 build → o_fwd_valid stays 0.
